// File: rtl/button_debouncer.sv
// Per-channel button debouncer: two-flop synchronizer, stability counter, debounced level, optional edge pulses.
// Latency: btn_db follows a held btn_raw level DB_CYCLES+2 clocks after the first sampling edge; pulses coincide with btn_db.
// No backpressure: a free-running, one-way signal path. Optional pulse outputs are enabled by macro BUTTON_DEBOUNCER_PULSE_EN.
module button_debouncer #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_db,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release
);

    // Terminal count: a level that differs from btn_db for this many counted clocks is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_CH-1:0]  s1_q;
    logic [N_CH-1:0]  s2_q;
    logic [N_CH-1:0]  db_q;
    logic [N_CH-1:0]  db_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Stability counting: any agreement with the accepted level restarts the count, so a bounce never accumulates.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end
        end
    end

    // Synchronizer, counters and debounced level; reset wins over every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            db_q <= db_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_db = db_q;

`ifdef BUTTON_DEBOUNCER_PULSE_EN
    logic [N_CH-1:0] press_q;
    logic [N_CH-1:0] release_q;
    logic [N_CH-1:0] press_d;
    logic [N_CH-1:0] release_d;

    // Edge detect on the next debounced level so the pulse lands on the same edge btn_db changes.
    always_comb begin
        press_d   = db_d & ~db_q;
        release_d = ~db_d & db_q;
    end

    // Pulse registers, cleared by reset so no pending pulse survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_press   = press_q;
    assign btn_release = release_q;
`else
    assign btn_press   = '0;
    assign btn_release = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int n_checks;
    int n_fail;

    button_debouncer #(
        .N_CH      (4),
        .DB_CYCLES (4),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pmask(input logic [3:0] v);
        return PULSE ? v : 4'b0000;
    endfunction

    // Inputs for a new level were just driven: btn_db must hold old_db for 5 edges,
    // switch to new_db on edge 6 with matching one-cycle pulses, and stay on edge 7.
    task automatic expect_change(input string tag, input logic [3:0] old_db, input logic [3:0] new_db);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("%s_db_e%0d", tag, i), btn_db, (i >= 6) ? new_db : old_db);
            chk($sformatf("%s_pr_e%0d", tag, i), btn_press,
                (i == 6) ? pmask(new_db & ~old_db) : 4'b0000);
            chk($sformatf("%s_rl_e%0d", tag, i), btn_release,
                (i == 6) ? pmask(~new_db & old_db) : 4'b0000);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        btn_raw  = 4'b0000;
        step();
        step();
        chk("rst_db", btn_db, 4'b0000);
        chk("rst_pr", btn_press, 4'b0000);
        chk("rst_rl", btn_release, 4'b0000);

        // Clean press on ch0.
        reset   = 1'b0;
        btn_raw = 4'b0001;
        expect_change("press0", 4'b0000, 4'b0001);

        // Bounce on ch1: each level lasts 2 clocks, too short to be accepted.
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = (k % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < 2; j++) begin
                step();
                chk($sformatf("bounce_db_%0d_%0d", k, j), btn_db, 4'b0001);
                chk($sformatf("bounce_pr_%0d_%0d", k, j), btn_press, 4'b0000);
            end
        end
        btn_raw[1] = 1'b1;
        expect_change("bounce1", 4'b0001, 4'b0011);

        // Release on ch2: first accept a press, then drop it.
        btn_raw[2] = 1'b1;
        expect_change("set2", 4'b0011, 4'b0111);
        btn_raw[2] = 1'b0;
        expect_change("rel2", 4'b0111, 4'b0011);

        // Reset three edges into a ch3 count; held levels are re-accepted as fresh presses.
        btn_raw[3] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("pre_rst_db_e%0d", i), btn_db, 4'b0011);
        end
        reset = 1'b1;
        step();
        chk("midrst_db", btn_db, 4'b0000);
        chk("midrst_pr", btn_press, 4'b0000);
        chk("midrst_rl", btn_release, 4'b0000);
        reset = 1'b0;
        expect_change("post_rst", 4'b0000, 4'b1011);

        // All low, then all four channels rise in the same cycle.
        btn_raw = 4'b0000;
        expect_change("all_lo", 4'b1011, 4'b0000);
        btn_raw = 4'b1111;
        expect_change("all_hi", 4'b0000, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
